// File: rtl/chacha20_block_packer_if.sv
// Word-in / block-out stream bundle for chacha20_block_packer.
// slave: the packer's view. master: the view of the environment that feeds words and sinks blocks.
interface chacha20_block_packer_if #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 16
);
    localparam int unsigned BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int unsigned CNT_W   = $clog2(BLOCK_WORDS + 1);

    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;
    logic [CNT_W-1:0]   out_words;
    logic               out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_block, out_words, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_words, out_last
    );
endinterface

// File: rtl/chacha20_block_packer.sv
// Gathers a 32-bit word stream into 512-bit blocks for the serial ChaCha20 encoder.
// Short final blocks are zero-padded; word count and last flag travel with each block.
// Optional build macro CHACHA20_PACKER_BSWAP_EN byte-reverses each word before storage.
module chacha20_block_packer #(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    chacha20_block_packer_if.slave  bus
);
    localparam int unsigned BLOCK_W = WORD_W * BLOCK_WORDS;
    localparam int unsigned IDX_W   = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W   = $clog2(BLOCK_WORDS + 1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0] abuf_q, abuf_d;
    logic [CNT_W-1:0]   held_words_q, held_words_d;
    logic               held_last_q, held_last_d;
    logic               in_ready_q;
    logic               out_valid_q, out_valid_d;
    logic [BLOCK_W-1:0] out_block_q, out_block_d;
    logic [CNT_W-1:0]   out_words_q, out_words_d;
    logic               out_last_q, out_last_d;

    logic [WORD_W-1:0]  word;
    logic [BLOCK_W-1:0] abuf_wr;
    logic [CNT_W-1:0]   count;
    logic               word_acc;
    logic               closing;
    logic               slot_free;

    // Word as it is stored in the block.
`ifdef CHACHA20_PACKER_BSWAP_EN
    assign word = {bus.in_data[7:0], bus.in_data[15:8], bus.in_data[23:16], bus.in_data[31:24]};
`else
    assign word = bus.in_data;
`endif

    assign word_acc  = (state_q == ACCUM) && bus.in_valid;
    assign closing   = word_acc && (bus.in_last || (idx_q == IDX_W'(BLOCK_WORDS - 1)));
    assign slot_free = !out_valid_q || bus.out_ready;
    assign count     = CNT_W'(idx_q) + CNT_W'(1);

    // Assembly buffer with the incoming word dropped into slot idx (word 0 at the MSBs).
    always_comb begin
        abuf_wr = abuf_q;
        for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                abuf_wr[BLOCK_W-1-k*WORD_W -: WORD_W] = word;
            end
        end
    end

    // Next-state: accumulate, close, hand off to the holding register, or stall.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        abuf_d       = abuf_q;
        held_words_d = held_words_q;
        held_last_d  = held_last_q;
        out_valid_d  = out_valid_q;
        out_block_d  = out_block_q;
        out_words_d  = out_words_q;
        out_last_d   = out_last_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ACCUM: begin
                if (word_acc) begin
                    if (closing) begin
                        idx_d = '0;
                        if (slot_free) begin
                            out_valid_d = 1'b1;
                            out_block_d = abuf_wr;
                            out_words_d = count;
                            out_last_d  = bus.in_last;
                            abuf_d      = '0;
                        end else begin
                            // Keep the finished block in abuf until the output drains.
                            abuf_d       = abuf_wr;
                            held_words_d = count;
                            held_last_d  = bus.in_last;
                            state_d      = STALL;
                        end
                    end else begin
                        abuf_d = abuf_wr;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            STALL: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b1;
                    out_block_d = abuf_q;
                    out_words_d = held_words_q;
                    out_last_d  = held_last_q;
                    abuf_d      = '0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State and output registers; reset and clear override everything.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q      <= ACCUM;
            idx_q        <= '0;
            abuf_q       <= '0;
            held_words_q <= '0;
            held_last_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_block_q  <= '0;
            out_words_q  <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            abuf_q       <= abuf_d;
            held_words_q <= held_words_d;
            held_last_q  <= held_last_d;
            in_ready_q   <= (state_d == ACCUM);
            out_valid_q  <= out_valid_d;
            out_block_q  <= out_block_d;
            out_words_q  <= out_words_d;
            out_last_q   <= out_last_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
    assign bus.out_words = out_words_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_chacha20_block_packer.sv
// Directed bench for chacha20_block_packer: vector table plus backpressure, throughput, clear and reset sequences.
module tb_chacha20_block_packer;
    logic clock = 1'b0;
    logic reset;
    logic clear;

    chacha20_block_packer_if bus ();

    chacha20_block_packer dut (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic [31:0] base;
        logic        last;
        logic [4:0]  exp_words;
        logic        exp_last;
        logic [31:0] exp_w0;
    } vec_t;

    typedef struct {
        logic [511:0] block;
        logic [4:0]   words;
        logic         last;
    } blk_t;

    blk_t mon_q[$];
    int   tests = 0;
    int   fails = 0;

    // Record every block that transfers at the following rising edge.
    always @(negedge clock) begin
        if (!reset && !clear && bus.out_valid && bus.out_ready) begin
            mon_q.push_back('{block: bus.out_block, words: bus.out_words, last: bus.out_last});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] stored(input logic [31:0] d);
`ifdef CHACHA20_PACKER_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Reference block: n consecutive words from base, zero beyond word n-1.
    function automatic logic [511:0] model_block(input logic [31:0] base, input int n);
        logic [511:0] r = '0;
        for (int k = 0; k < n; k++) begin
            r[511-32*k -: 32] = stored(base + 32'(k));
        end
        return r;
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l);
        bit ok = 0;
        bit rdy;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            rdy = bus.in_ready;
            @(posedge clock);
            #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %0h not accepted, in_ready stuck at %0b", d, bus.in_ready);
        end
    endtask

    task automatic send_run(input logic [31:0] base, input int n, input logic last);
        for (int k = 0; k < n; k++) begin
            send_word(base + 32'(k), last && (k == n - 1));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pop_block(output blk_t b, output bit ok);
        for (int i = 0; i < 200 && mon_q.size() == 0; i++) begin
            @(posedge clock);
        end
        ok = (mon_q.size() != 0);
        if (ok) b = mon_q.pop_front();
        else    b = '{block: '0, words: '0, last: 1'b0};
    endtask

    task automatic expect_block(input string name, input logic [31:0] base, input int n, input logic last);
        blk_t b;
        bit   ok;
        pop_block(b, ok);
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no block seen, expected words=%0d", name, n);
        end else begin
            check({name, "_block"}, b.block, model_block(base, n));
            check({name, "_words"}, 512'(b.words), 512'(n));
            check({name, "_last"}, 512'(b.last), 512'(last));
        end
    endtask

    initial begin
        vec_t vecs[5];
        blk_t b;
        bit   ok;
        int   bad_rdy;
        int   bad_pulse;
        logic [511:0] pad_mask;

        vecs[0] = '{n: 16, base: 32'h0000_0001, last: 1'b0, exp_words: 5'd16, exp_last: 1'b0, exp_w0: 32'h0000_0001};
        vecs[1] = '{n: 5,  base: 32'h0000_00A0, last: 1'b1, exp_words: 5'd5,  exp_last: 1'b1, exp_w0: 32'h0000_00A0};
        vecs[2] = '{n: 1,  base: 32'h0000_0077, last: 1'b1, exp_words: 5'd1,  exp_last: 1'b1, exp_w0: 32'h0000_0077};
        vecs[3] = '{n: 16, base: 32'h0000_0040, last: 1'b1, exp_words: 5'd16, exp_last: 1'b1, exp_w0: 32'h0000_0040};
`ifdef CHACHA20_PACKER_BSWAP_EN
        vecs[4] = '{n: 1,  base: 32'h1122_3344, last: 1'b1, exp_words: 5'd1,  exp_last: 1'b1, exp_w0: 32'h4433_2211};
        vecs[0].exp_w0 = 32'h0100_0000;
        vecs[1].exp_w0 = 32'hA000_0000;
        vecs[2].exp_w0 = 32'h7700_0000;
        vecs[3].exp_w0 = 32'h4000_0000;
`else
        vecs[4] = '{n: 1,  base: 32'h1122_3344, last: 1'b1, exp_words: 5'd1,  exp_last: 1'b1, exp_w0: 32'h1122_3344};
`endif

        reset         = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clock);
        check("rst_out_valid", 512'(bus.out_valid), 512'(0));
        check("rst_in_ready", 512'(bus.in_ready), 512'(1));
        check("rst_out_block", bus.out_block, 512'(0));
        check("rst_out_words", 512'(bus.out_words), 512'(0));
        check("rst_out_last", 512'(bus.out_last), 512'(0));
        @(posedge clock);
        #1;

        // Table: full, short, single, last-at-16, single-word byte order.
        bus.out_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            send_run(vecs[v].base, vecs[v].n, vecs[v].last);
            @(negedge clock);
            check($sformatf("vec%0d_latency", v), 512'(bus.out_valid), 512'(1));
            pop_block(b, ok);
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL vec%0d_timeout: no block seen", v);
            end else begin
                pad_mask = (vecs[v].n < 16) ? ({512{1'b1}} >> (32 * vecs[v].n)) : '0;
                check($sformatf("vec%0d_block", v), b.block, model_block(vecs[v].base, vecs[v].n));
                check($sformatf("vec%0d_w0", v), 512'(b.block[511:480]), 512'(vecs[v].exp_w0));
                check($sformatf("vec%0d_pad", v), b.block & pad_mask, 512'(0));
                check($sformatf("vec%0d_words", v), 512'(b.words), 512'(vecs[v].exp_words));
                check($sformatf("vec%0d_last", v), 512'(b.last), 512'(vecs[v].exp_last));
            end
            @(posedge clock);
            #1;
        end
        check("vec_full_w15", model_block(32'h1, 16) & 512'hFFFF_FFFF, 512'(stored(32'h10)));

        // Backpressure: two blocks, second one stalls in abuf.
        bus.out_ready = 1'b0;
        send_run(32'h100, 32, 1'b0);
        @(negedge clock);
        check("bp_stall_in_ready", 512'(bus.in_ready), 512'(0));
        check("bp_hold_valid", 512'(bus.out_valid), 512'(1));
        check("bp_hold_block_a", bus.out_block, model_block(32'h100, 16));
        @(negedge clock);
        check("bp_hold_block_b", bus.out_block, model_block(32'h100, 16));
        check("bp_hold_words", 512'(bus.out_words), 512'(16));
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        check("bp_blk2_valid", 512'(bus.out_valid), 512'(1));
        check("bp_blk2_block", bus.out_block, model_block(32'h110, 16));
        check("bp_resume_in_ready", 512'(bus.in_ready), 512'(1));
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        expect_block("bp_first", 32'h100, 16, 1'b0);
        expect_block("bp_second", 32'h110, 16, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        check("bp_no_extra", 512'(mon_q.size()), 512'(0));
        check("bp_drained", 512'(bus.out_valid), 512'(0));

        // Throughput: 48 back-to-back words with out_ready held high.
        bad_rdy   = 0;
        bad_pulse = 0;
        for (int i = 0; i < 48; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h200 + 32'(i);
            bus.in_last  = 1'b0;
            @(negedge clock);
            if (!bus.in_ready) bad_rdy++;
            if (i > 0 && bus.out_valid !== (((i - 1) % 16) == 15)) bad_pulse++;
            @(posedge clock);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clock);
        if (bus.out_valid !== 1'b1) bad_pulse++;
        check("tp_in_ready_drops", 512'(bad_rdy), 512'(0));
        check("tp_pulse_errors", 512'(bad_pulse), 512'(0));
        expect_block("tp_blk0", 32'h200, 16, 1'b0);
        expect_block("tp_blk1", 32'h210, 16, 1'b0);
        expect_block("tp_blk2", 32'h220, 16, 1'b0);
        @(posedge clock);
        #1;

        // Clear mid-block drops the partial block.
        send_run(32'h300, 7, 1'b0);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        @(negedge clock);
        check("clr_in_ready", 512'(bus.in_ready), 512'(1));
        check("clr_out_valid", 512'(bus.out_valid), 512'(0));
        @(posedge clock);
        #1;
        send_run(32'hB0, 16, 1'b0);
        expect_block("clr_after", 32'hB0, 16, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check("clr_no_extra", 512'(mon_q.size()), 512'(0));

        // Reset while in STALL drops both held blocks.
        bus.out_ready = 1'b0;
        send_run(32'h400, 32, 1'b0);
        @(negedge clock);
        check("rs_stall_in_ready", 512'(bus.in_ready), 512'(0));
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rs_out_valid", 512'(bus.out_valid), 512'(0));
        check("rs_out_words", 512'(bus.out_words), 512'(0));
        check("rs_out_block", bus.out_block, 512'(0));
        check("rs_in_ready", 512'(bus.in_ready), 512'(1));
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        send_run(32'h55, 1, 1'b1);
        expect_block("rs_after", 32'h55, 1, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        check("rs_no_extra", 512'(mon_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
